// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the execute-stage ALU sequencer.
// Contents: datapath width, op codes seen on in_op / alu_ctrl, sequencer
// state encodings, default ALU settle time and the shift-add helpers used by
// the multiplier datapath.
package alu_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int SETTLE_DEFAULT = 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_MUL  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Partial product added to the accumulator in shift-add step idx.
  function automatic logic [DATA_WIDTH-1:0] partial_product(
    input logic [DATA_WIDTH-1:0] mcand,
    input logic [DATA_WIDTH-1:0] mplier,
    input logic [4:0]            idx
  );
    return mplier[idx] ? (mcand << idx) : '0;
  endfunction

  // True when step idx drops multiplicand bits off the top of the word,
  // which means the full product cannot fit in 32 bits.
  function automatic logic bits_lost(
    input logic [DATA_WIDTH-1:0] mcand,
    input logic [DATA_WIDTH-1:0] mplier,
    input logic [4:0]            idx
  );
    logic [2*DATA_WIDTH-1:0] wide;
    wide = {{DATA_WIDTH{1'b0}}, mcand} << idx;
    return mplier[idx] && (wide[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
  endfunction

endpackage

// File: rtl/alu_mul_datapath.sv
// alu_mul_datapath: operand registers, step counter and overflow tracking for
// the 32-step shift-add multiply executed on the external ALU in ADD mode.
// The accumulator is the sequencer's alu_a port register itself (each step
// adds into it through the ALU), so it is not duplicated here.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            MUL accepted: capture operands, restart at step 0
//   step_done       current step's settle window ends this edge
//   in_a, in_b      multiplicand / multiplier from decode
//   alu_cout        ALU carry out of the current step's addition
//   first_b         ALU B operand for step 0 (from in_a/in_b, used at load)
//   next_b          ALU B operand for the step after the current one
//   last_step       current step is step 31
//   overflow_total  overflow including the current step (valid at step end)
module alu_mul_datapath
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step_done,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  alu_cout,
  output logic [DATA_WIDTH-1:0] first_b,
  output logic [DATA_WIDTH-1:0] next_b,
  output logic                  last_step,
  output logic                  overflow_total
);

  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [4:0]            step;
  logic [4:0]            next_idx;
  logic                  ovf;

  assign next_idx       = step + 5'd1;
  assign first_b        = in_b[0] ? in_a : '0;
  assign next_b         = partial_product(mcand, mplier, next_idx);
  assign last_step      = (step == 5'd31);
  assign overflow_total = ovf | alu_cout | bits_lost(mcand, mplier, step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      step   <= '0;
      ovf    <= 1'b0;
    end else if (load) begin
      mcand  <= in_a;
      mplier <= in_b;
      step   <= '0;
      ovf    <= 1'b0;
    end else if (step_done) begin
      step <= next_idx;
      ovf  <= overflow_total;
    end
  end

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: execute-stage sequencer in front of the 32-bit gate-level ALU.
// Accepts one op over in_valid/in_ready, drives registered operands and Ctrl
// to the ALU, waits ALU_SETTLE_CYCLES (>= 1) clocks, then captures the ALU
// outputs into a held result offered over out_valid/out_ready. MUL runs as a
// 32-step shift-add loop on the ALU in ADD mode.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            operation handshake from decode
//   in_a, in_b, in_op            operands and op code (sampled at accept only)
//   alu_a, alu_b, alu_ctrl       registered ALU inputs
//   alu_out/zero/overflow/cout   ALU outputs
//   out_valid/out_ready          result handshake to writeback
//   out_result/zero/overflow/cout/err  held result and flags
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int ALU_SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter int WIDTH             = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_cout,
  output logic             out_err
);

  localparam int CW = (ALU_SETTLE_CYCLES > 1) ? $clog2(ALU_SETTLE_CYCLES) : 1;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic            accept;
  logic            settle_last;
  logic            mul_step_done;
  logic            mul_last_step;
  logic            mul_ovf;
  logic [WIDTH-1:0] mul_first_b;
  logic [WIDTH-1:0] mul_next_b;

  assign accept        = in_valid & in_ready;
  assign settle_last   = (settle_cnt == CW'(ALU_SETTLE_CYCLES - 1));
  assign mul_step_done = (state == ST_MUL) && settle_last;
  assign out_valid     = (state == ST_DONE);

  alu_mul_datapath u_mul (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (accept && (in_op == OP_MUL)),
    .step_done      (mul_step_done),
    .in_a           (in_a),
    .in_b           (in_b),
    .alu_cout       (alu_cout),
    .first_b        (mul_first_b),
    .next_b         (mul_next_b),
    .last_step      (mul_last_step),
    .overflow_total (mul_ovf)
  );

  // in_ready is a register so that it stays low during reset and rises one
  // edge after release, even though the state is already IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      settle_cnt   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= '0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_cout     <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready   <= 1'b0;
            settle_cnt <= '0;
            if (!in_op[2]) begin
              alu_a    <= in_a;
              alu_b    <= in_b;
              alu_ctrl <= in_op;
              state    <= ST_EXEC;
            end else if (in_op == OP_MUL) begin
              // Step 0 starts from an empty accumulator.
              alu_a    <= '0;
              alu_b    <= mul_first_b;
              alu_ctrl <= OP_ADD;
              state    <= ST_MUL;
            end else begin
              out_result   <= '0;
              out_zero     <= 1'b0;
              out_overflow <= 1'b0;
              out_cout     <= 1'b0;
              out_err      <= 1'b1;
              state        <= ST_DONE;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (settle_last) begin
            out_result   <= alu_out;
            out_zero     <= alu_zero;
            out_overflow <= alu_overflow;
            out_cout     <= alu_cout;
            out_err      <= 1'b0;
            state        <= ST_DONE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_MUL: begin
          if (settle_last) begin
            settle_cnt <= '0;
            if (mul_last_step) begin
              out_result   <= alu_out;
              out_zero     <= (alu_out == '0);
              out_overflow <= mul_ovf;
              out_cout     <= 1'b0;
              out_err      <= 1'b0;
              state        <= ST_DONE;
            end else begin
              alu_a <= alu_out;
              alu_b <= mul_next_b;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: begin
          if (out_ready) begin
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: bench for alu_issue_seq. Two instances (settle 1 and 2)
// each drive a behavioural model of the gate-level ALU; results are checked
// against a reference computed with plain 64-bit arithmetic.
module tb_alu_issue_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid[2], in_ready[2], out_valid[2], out_ready[2];
  logic        out_zero[2], out_overflow[2], out_cout[2], out_err[2];
  logic        alu_zero[2], alu_overflow[2], alu_cout[2];
  logic [31:0] in_a[2], in_b[2], alu_a[2], alu_b[2], alu_out[2], out_result[2];
  logic [2:0]  in_op[2], alu_ctrl[2];

  int vectors;
  int miscompares;

  // Gate-level ALU stand-in: {cout, overflow, out}.
  function automatic logic [33:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] ctrl);
    logic [32:0] s;
    case (ctrl)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        return {s[32], (a[31] == b[31]) && (s[31] != a[31]), s[31:0]};
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        return {s[32], (a[31] != b[31]) && (s[31] != a[31]), s[31:0]};
      end
      3'b010:  return {2'b00, a ^ b};
      3'b011:  return {2'b00, 31'd0, ($signed(a) < $signed(b))};
      default: return 34'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign {alu_cout[g], alu_overflow[g], alu_out[g]} = alu_model(alu_a[g], alu_b[g], alu_ctrl[g]);
    assign alu_zero[g] = (alu_out[g] == 32'd0);

    alu_issue_seq #(.ALU_SETTLE_CYCLES(g + 1), .WIDTH(32)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .in_a         (in_a[g]),
      .in_b         (in_b[g]),
      .in_op        (in_op[g]),
      .alu_a        (alu_a[g]),
      .alu_b        (alu_b[g]),
      .alu_ctrl     (alu_ctrl[g]),
      .alu_out      (alu_out[g]),
      .alu_zero     (alu_zero[g]),
      .alu_overflow (alu_overflow[g]),
      .alu_cout     (alu_cout[g]),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready[g]),
      .out_result   (out_result[g]),
      .out_zero     (out_zero[g]),
      .out_overflow (out_overflow[g]),
      .out_cout     (out_cout[g]),
      .out_err      (out_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: what the operation means arithmetically.
  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic zero, output logic ovf,
                           output logic cout, output logic err);
    longint unsigned ua, ub, u;
    longint          sa, sb, ss;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 0; ovf = 0; cout = 0; err = 0;
    case (op)
      3'b000: begin
        u = ua + ub; res = 32'(u); cout = (u >= 64'h1_0000_0000);
        ss = sa + sb; ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'b001: begin
        res = 32'(ua - ub); cout = (ua >= ub);
        ss = sa - sb; ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'b010: res = a ^ b;
      3'b011: res = (sa < sb) ? 32'd1 : 32'd0;
      3'b100: begin
        u = ua * ub; res = 32'(u); ovf = (u >= 64'h1_0000_0000);
      end
      default: err = 1;
    endcase
    zero = !err && (res == 0);
  endtask

  function automatic int exp_latency(input int k, input logic [2:0] op);
    int s;
    s = k + 1;
    if (op == 3'b100) return 32 * s + 1;
    if (op[2])        return 1;
    return s + 1;
  endfunction

  task automatic apply_stimulus(input int k, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int hold);
    logic [31:0] e_res, pre_a, pre_b;
    logic [2:0]  pre_c;
    logic        e_zero, e_ovf, e_cout, e_err;
    int          lat, waited;
    ref_model(op, a, b, e_res, e_zero, e_ovf, e_cout, e_err);
    @(negedge clk);
    waited = 0;
    while (in_ready[k] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output("in_ready_idle", in_ready[k], 1);
    pre_a = alu_a[k]; pre_b = alu_b[k]; pre_c = alu_ctrl[k];
    in_valid[k] = 1'b1; in_a[k] = a; in_b[k] = b; in_op[k] = op;
    @(posedge clk); #1;
    in_valid[k] = 1'b0; in_a[k] = $urandom; in_b[k] = $urandom; in_op[k] = 3'($urandom);
    lat = 1;
    while (out_valid[k] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("latency", lat, exp_latency(k, op));
    check_output("result", out_result[k], e_res);
    check_output("zero", out_zero[k], e_zero);
    check_output("overflow", out_overflow[k], e_ovf);
    check_output("cout", out_cout[k], e_cout);
    check_output("err", out_err[k], e_err);
    check_output("in_ready_busy", in_ready[k], 0);
    if (e_err) begin
      check_output("illegal_alu_a", alu_a[k], pre_a);
      check_output("illegal_alu_b", alu_b[k], pre_b);
      check_output("illegal_alu_ctrl", alu_ctrl[k], pre_c);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_output("hold_valid", out_valid[k], 1);
      check_output("hold_result", out_result[k], e_res);
      check_output("hold_in_ready", in_ready[k], 0);
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    check_output("handshake_valid", out_valid[k], 0);
    check_output("handshake_in_ready", in_ready[k], 1);
    check_output("result_kept", out_result[k], e_res);
  endtask

  task automatic check_reset_outputs(input int k);
    check_output("rst_result", out_result[k], 0);
    check_output("rst_alu_a", alu_a[k], 0);
    check_output("rst_alu_b", alu_b[k], 0);
    check_output("rst_flags", {in_ready[k], out_valid[k], out_zero[k], out_overflow[k],
                               out_cout[k], out_err[k], alu_ctrl[k]}, 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 0; in_a[k] = 0; in_b[k] = 0; in_op[k] = 0; out_ready[k] = 0;
    end

    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) check_reset_outputs(k);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("in_ready_before_edge", in_ready[0], 0);
    @(posedge clk); #1;
    check_output("in_ready_after_edge", in_ready[0], 1);

    $display("[TB] directed operations");
    apply_stimulus(0, 3'b000, 32'd4000000000, 32'd4000000000, 0);
    check_output("add_big_literal", out_result[0], 32'd3705032704);
    apply_stimulus(0, 3'b001, 32'd7, 32'd7, 0);
    check_output("sub_zero_literal", out_zero[0], 1);
    apply_stimulus(0, 3'b011, 32'd5, 32'd7, 0);
    check_output("slt_literal", out_result[0], 1);
    apply_stimulus(1, 3'b100, 32'd1234, 32'd5678, 0);
    check_output("mul_literal", out_result[1], 32'd7006652);
    apply_stimulus(1, 3'b100, 32'd65536, 32'd65536, 0);
    check_output("mul_wrap_ovf", out_overflow[1], 1);
    apply_stimulus(1, 3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 10);
    check_output("xor_literal", out_result[1], 32'hF0F00F0F);
    apply_stimulus(0, 3'b111, 32'd9, 32'd9, 1);
    apply_stimulus(1, 3'b101, 32'd3, 32'd4, 0);
    apply_stimulus(0, 3'b001, 32'h8000_0000, 32'd1, 0);
    apply_stimulus(0, 3'b000, 32'h7FFF_FFFF, 32'd1, 0);
    apply_stimulus(1, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    $display("[TB] random operations");
    for (int n = 0; n < 24; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (op == 3'b100 && $urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, 65535);
        b = $urandom_range(0, 65535);
      end
      apply_stimulus(n % 2, op, a, b, $urandom_range(0, 3));
    end

    $display("[TB] reset during multiply");
    @(negedge clk);
    in_valid[1] = 1'b1; in_a[1] = 32'd12345; in_b[1] = 32'hFFFF_FFFF; in_op[1] = 3'b100;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (21) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(1);
    check_reset_outputs(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("in_ready_after_reset", in_ready[1], 1);
    apply_stimulus(1, 3'b000, 32'd1, 32'd2, 0);
    check_output("add_after_reset", out_result[1], 32'd3);
    apply_stimulus(0, 3'b000, 32'd1, 32'd2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
